// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one tx_module between NUM_REQ byte requesters.
// Each grant latches one byte and the line config, then tracks start, busy and done.
module tx_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5,
  parameter int START_TIMEOUT    = 4096
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 tx_en_i,
  input  logic [TOTAL_CONF_WIDTH-1:0]          conf_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ*MAX_UART_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic                                 tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]           tx_data_o,
  output logic [TOTAL_CONF_WIDTH-1:0]          tx_conf_o,
  input  logic                                 tx_busy_i,
  input  logic                                 tx_done_i,
  output logic [NUM_REQ-1:0]                   grant_o,
  output logic                                 done_o,
  output logic                                 timeout_o
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [PTR_W-1:0]              ptr_reg, ptr_next;
  logic [TIMER_W-1:0]            timer_reg, timer_next;
  logic                          start_reg, start_next;
  logic [MAX_UART_DATA_W-1:0]    data_reg, data_next;
  logic [TOTAL_CONF_WIDTH-1:0]   conf_reg, conf_next;
  logic [NUM_REQ-1:0]            grant_reg, grant_next;

  logic [MAX_UART_DATA_W-1:0]    req_bytes [NUM_REQ];
  logic [PTR_W-1:0]              cand [NUM_REQ];
  logic [NUM_REQ-1:0]            cand_valid;
  logic                          pick_found;
  logic [PTR_W-1:0]              pick_idx;

  // cand[gi] is the requester at search position gi, i.e. (ptr + 1 + gi) mod NUM_REQ
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [PTR_W:0] sum;
    assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi + 1);
    assign cand[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                   : sum[PTR_W-1:0];
    assign cand_valid[gi] = req_valid_i[cand[gi]];
    assign req_bytes[gi]  = req_data_i[gi*MAX_UART_DATA_W +: MAX_UART_DATA_W];
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand[k];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    timer_next  = timer_reg;
    start_next  = start_reg;
    data_next   = data_reg;
    conf_next   = conf_reg;
    grant_next  = grant_reg;
    req_ready_o = '0;
    done_o      = 1'b0;
    timeout_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_en_i && pick_found) begin
          req_ready_o = NUM_REQ'(1) << pick_idx;
          data_next   = req_bytes[pick_idx];
          conf_next   = conf_i;
          grant_next  = NUM_REQ'(1) << pick_idx;
          ptr_next    = pick_idx;
          start_next  = 1'b1;
          timer_next  = '0;
          state_next  = START;
        end
      end
      START: begin
        // busy wins over an expiring timer in the same cycle
        if (tx_busy_i) begin
          start_next = 1'b0;
          state_next = BUSY;
        end else if (timer_reg == TIMER_W'(START_TIMEOUT - 1)) begin
          timeout_o  = 1'b1;
          start_next = 1'b0;
          grant_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      BUSY: begin
        if (tx_done_i) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= PTR_W'(NUM_REQ - 1);
      timer_reg <= '0;
      start_reg <= 1'b0;
      data_reg  <= '0;
      conf_reg  <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      timer_reg <= timer_next;
      start_reg <= start_next;
      data_reg  <= data_next;
      conf_reg  <= conf_next;
      grant_reg <= grant_next;
    end
  end

  assign tx_start_o = start_reg;
  assign tx_data_o  = data_reg;
  assign tx_conf_o  = conf_reg;
  assign grant_o    = grant_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter; tx_module handshake (busy/done) is driven by hand.
module tb_tx_arbiter;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int CW = 5;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tx_en = 1'b0;
  logic [CW-1:0]   conf = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [W-1:0]    tx_data;
  logic [CW-1:0]   tx_conf;
  logic            tx_busy = 1'b0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    grant;
  logic            done;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  tx_arbiter #(
    .NUM_REQ(N), .MAX_UART_DATA_W(W), .TOTAL_CONF_WIDTH(CW), .START_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .conf_i(conf),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_conf_o(tx_conf),
    .tx_busy_i(tx_busy), .tx_done_i(tx_done), .grant_o(grant),
    .done_o(done), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE with valids already set; ends at the negedge back in IDLE.
  task automatic frame(input logic [N-1:0] eg, input logic [W-1:0] ed, input logic [CW-1:0] ec);
    #1;
    check("ready_at_grant", 32'(req_ready), 32'(eg));
    @(negedge clk);
    check("start_after_grant", 32'(tx_start), 32'd1);
    check("grant_in_start", 32'(grant), 32'(eg));
    check("data_latched", 32'(tx_data), 32'(ed));
    check("conf_latched", 32'(tx_conf), 32'(ec));
    check("ready_in_start", 32'(req_ready), 32'd0);
    tx_busy = 1'b1;
    @(negedge clk);
    check("start_dropped", 32'(tx_start), 32'd0);
    check("ready_in_busy", 32'(req_ready), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("grant_in_done", 32'(grant), 32'(eg));
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("grant_cleared", 32'(grant), 32'd0);
    $display("frame: grant=%b data=%h conf=%b", eg, ed, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_conf", 32'(tx_conf), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single req0 byte
    tx_en = 1'b1;
    conf = 5'b11011;
    req_data = {8'h00, 8'hA5};
    req_valid = 2'b01;
    frame(2'b01, 8'hA5, 5'b11011);
    req_valid = 2'b00;
    @(negedge clk);

    // both valid: last grant was 0, so 1,0,1,0
    done_cnt = 0;
    conf = 5'b00100;
    req_data = {8'h22, 8'h11};
    req_valid = 2'b11;
    frame(2'b10, 8'h22, 5'b00100);
    frame(2'b01, 8'h11, 5'b00100);
    frame(2'b10, 8'h22, 5'b00100);
    frame(2'b01, 8'h11, 5'b00100);
    req_valid = 2'b00;
    check("done_count", 32'(done_cnt), 32'd4);
    @(negedge clk);

    // busy never rises: timeout after TO cycles of tx_start
    req_data = {8'h5C, 8'h00};
    req_valid = 2'b10;
    #1;
    check("ready_req1", 32'(req_ready), 32'b10);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 2'b00;
      check("to_start_held", 32'(tx_start), 32'd1);
      check("to_grant_held", 32'(grant), 32'b10);
      check("to_pulse", 32'(timeout), 32'(i == TO - 1));
    end
    $display("timeout: grant=10 after %0d cycles", TO);
    @(negedge clk);
    check("to_start_off", 32'(tx_start), 32'd0);
    check("to_grant_off", 32'(grant), 32'd0);
    check("to_pulse_off", 32'(timeout), 32'd0);

    // busy rises on the last allowed cycle
    req_data = {8'h00, 8'h3C};
    req_valid = 2'b01;
    #1;
    check("ready_req0_late", 32'(req_ready), 32'b01);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 2'b00;
      if (i == TO - 1) begin
        tx_busy = 1'b1;
        #1;
      end
      check("late_no_timeout", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    check("late_in_busy_start", 32'(tx_start), 32'd0);
    check("late_in_busy_grant", 32'(grant), 32'b01);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    check("late_done", 32'(done), 32'd1);
    $display("late busy: frame completed without timeout");
    @(negedge clk);

    // tx_en dropped mid-frame
    req_data = {8'h00, 8'h77};
    req_valid = 2'b01;
    #1;
    check("en_ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    check("en_off_done", 32'(done), 32'd1);
    @(negedge clk);
    check("en_off_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("en_off_no_start", 32'(tx_start), 32'd0);
    check("en_off_no_grant", 32'(grant), 32'd0);
    tx_en = 1'b1;
    #1;
    check("en_on_ready", 32'(req_ready), 32'b01);
    $display("tx_en drop: frame finished, regrant held off");

    // reset during BUSY
    @(negedge clk);
    req_valid = 2'b00;
    check("pre_rst_start", 32'(tx_start), 32'd1);
    tx_busy = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_conf", 32'(tx_conf), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    check("post_rst_ready0", 32'(req_ready), 32'b01);
    $display("reset mid-frame: req0 first after release");
    req_valid = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
